// File: rtl/car_sensor_gen.sv
// Emulates the a/b sensor pair of a car passing through a parking-meter gate.
// Each request plays P1->P2->P3->GAP, each phase hold_eff cycles, and updates occupancy.
module car_sensor_gen #(
    parameter int unsigned HOLD_W = 8,
    parameter int unsigned OCC_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              dir,
    input  logic [HOLD_W-1:0] hold,
    input  logic              abort,
    output logic              a,
    output logic              b,
    output logic              busy,
    output logic              done,
    output logic [OCC_W-1:0]  occupancy
);

    typedef enum logic [2:0] {StIdle, StP1, StP2, StP3, StGap} state_e;

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   cnt_q, cnt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                dir_q, dir_d;
    logic                a_q, a_d, b_q, b_d, busy_q, busy_d, done_q, done_d;
    logic [OCC_W-1:0]    occ_q, occ_d;
    logic [HOLD_W-1:0]   hold_eff;
    logic                expire;
    logic                seq_done;

    assign hold_eff = (hold == '0) ? HOLD_W'(1) : hold;
    assign expire   = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hold_q  <= '0;
            dir_q   <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            dir_q   <= dir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            occ_q   <= occ_d;
        end
    end

    // Counter counts down from hold_eff-1; a phase ends when it reaches zero.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        dir_d    = dir_q;
        seq_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StP1;
                    dir_d   = dir;
                    hold_d  = hold_eff;
                    cnt_d   = hold_eff - HOLD_W'(1);
                end
            end
            StP1, StP2, StP3: begin
                if (expire) begin
                    state_d = (state_q == StP1) ? StP2 : (state_q == StP2) ? StP3 : StGap;
                    cnt_d   = hold_q - HOLD_W'(1);
                end else begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end
            end
            StGap: begin
                if (expire) begin
                    state_d  = StIdle;
                    cnt_d    = '0;
                    seq_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
        if (abort && state_q != StIdle) begin
            state_d  = StIdle;
            cnt_d    = '0;
            seq_done = 1'b0;
        end
    end

    // Outputs are registered from the next state so they track state_q exactly.
    always_comb begin
        a_d    = 1'b0;
        b_d    = 1'b0;
        busy_d = (state_d != StIdle);
        done_d = seq_done;
        occ_d  = occ_q;
        unique case (state_d)
            StP1:    begin a_d = ~dir_d; b_d = dir_d;  end
            StP2:    begin a_d = 1'b1;   b_d = 1'b1;   end
            StP3:    begin a_d = dir_d;  b_d = ~dir_d; end
            default: begin a_d = 1'b0;   b_d = 1'b0;   end
        endcase
        if (seq_done) begin
            if (!dir_q && occ_q != '1) begin
                occ_d = occ_q + OCC_W'(1);
            end else if (dir_q && occ_q != '0) begin
                occ_d = occ_q - OCC_W'(1);
            end
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_car_sensor_gen.sv
// Bench for car_sensor_gen: directed vector table, corner sequences and random
// stimulus compared against a cycle-position reference model.
module tb_car_sensor_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0, start = 1'b0, dir = 1'b0, abort = 1'b0;
    logic [7:0] hold = 8'd0;
    logic       a, b, busy, done;
    logic [7:0] occupancy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: position within the 4*h-cycle sequence.
    bit m_active = 0, m_dir = 0, m_done = 0;
    int m_t = 0, m_h = 1, m_occ = 0;

    always #5 clk = ~clk;

    car_sensor_gen #(.HOLD_W(8), .OCC_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dir       (dir),
        .hold      (hold),
        .abort     (abort),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .occupancy (occupancy)
    );

    typedef struct {
        logic       rst, st, dr;
        logic [7:0] hd;
        logic       ab;
        logic [11:0] exp;  // {a, b, busy, done, occupancy}
    } vec_t;

    function automatic vec_t mk(logic rst, logic st, logic dr, logic [7:0] hd, logic ab,
                                logic [1:0] ab_pat, logic bsy, logic dn, logic [7:0] occ);
        vec_t v;
        v.rst = rst; v.st = st; v.dr = dr; v.hd = hd; v.ab = ab;
        v.exp = {ab_pat, bsy, dn, occ};
        return v;
    endfunction

    function automatic logic [11:0] model_word();
        logic [1:0] p;
        int ph;
        p = 2'b00;
        if (m_active) begin
            ph = m_t / m_h;
            case (ph)
                0: p = m_dir ? 2'b01 : 2'b10;
                1: p = 2'b11;
                2: p = m_dir ? 2'b10 : 2'b01;
                default: p = 2'b00;
            endcase
        end
        return {p, m_active, m_done, 8'(m_occ)};
    endfunction

    task automatic model_step(logic rst, logic st, logic dr, logic [7:0] hd, logic ab);
        m_done = 0;
        if (rst) begin
            m_active = 0; m_occ = 0; m_t = 0; m_h = 1; m_dir = 0;
        end else if (m_active) begin
            if (ab) begin
                m_active = 0;
            end else begin
                m_t++;
                if (m_t == 4 * m_h) begin
                    m_active = 0;
                    m_done = 1;
                    if (m_dir) m_occ = (m_occ > 0) ? m_occ - 1 : 0;
                    else       m_occ = (m_occ < 255) ? m_occ + 1 : 255;
                end
            end
        end else if (st && !ab) begin
            m_active = 1; m_t = 0; m_dir = dr;
            m_h = (hd == 0) ? 1 : int'(hd);
        end
    endtask

    task automatic check(string name, logic [11:0] exp);
        logic [11:0] act;
        act = {a, b, busy, done, occupancy};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got ab=%b%b busy=%b done=%b occ=%0d, want ab=%b%b busy=%b done=%b occ=%0d",
                     name, $time, act[11], act[10], act[9], act[8], act[7:0],
                     exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    // Drive inputs away from the rising edge, step the model on it, sample on the falling edge.
    task automatic run_step(logic rst, logic st, logic dr, logic [7:0] hd, logic ab);
        reset = rst; start = st; dir = dr; hold = hd; abort = ab;
        @(posedge clk);
        model_step(rst, st, dr, hd, ab);
        @(negedge clk);
    endtask

    task automatic step_chk(string name, logic rst, logic st, logic dr, logic [7:0] hd, logic ab);
        run_step(rst, st, dr, hd, ab);
        check(name, model_word());
    endtask

    vec_t vecs[18];

    initial begin
        vecs[0]  = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        vecs[1]  = mk(0, 1, 0, 2, 0, 2'b10, 1, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 2'b10, 1, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 2'b11, 1, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 2'b11, 1, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 2'b01, 1, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 2'b01, 1, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 2'b00, 1, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0, 0, 2'b00, 1, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 2'b00, 0, 1, 1);
        vecs[10] = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
        vecs[11] = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        vecs[12] = mk(0, 1, 1, 0, 0, 2'b01, 1, 0, 0);
        vecs[13] = mk(0, 0, 0, 0, 0, 2'b11, 1, 0, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 2'b10, 1, 0, 0);
        vecs[15] = mk(0, 0, 0, 0, 0, 2'b00, 1, 0, 0);
        vecs[16] = mk(0, 0, 0, 0, 0, 2'b00, 0, 1, 0);
        vecs[17] = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);

        @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            run_step(vecs[i].rst, vecs[i].st, vecs[i].dr, vecs[i].hd, vecs[i].ab);
            check($sformatf("table[%0d]", i), vecs[i].exp);
        end

        // Entry with hold=3, abort in the 2nd cycle of P2.
        step_chk("abort_start", 0, 1, 0, 3, 0);
        for (int i = 0; i < 4; i++) step_chk("abort_run", 0, 0, 0, 0, 0);
        step_chk("abort_hit", 0, 0, 0, 0, 1);
        check("abort_idle", 12'b00_0_0_00000000);
        step_chk("abort_after", 0, 0, 0, 0, 0);

        // Entry hold=1, start while busy ignored, start in done cycle begins exit.
        step_chk("b2b_entry", 0, 1, 0, 1, 0);
        step_chk("b2b_ignored", 0, 1, 1, 5, 0);
        step_chk("b2b_p3", 0, 0, 0, 0, 0);
        step_chk("b2b_gap", 0, 0, 0, 0, 0);
        step_chk("b2b_done", 0, 0, 0, 0, 0);
        check("b2b_done_occ1", 12'b00_0_1_00000001);
        step_chk("b2b_exit_p1", 0, 1, 1, 1, 0);
        check("b2b_exit_pat", 12'b01_1_0_00000001);
        for (int i = 0; i < 4; i++) step_chk("b2b_exit", 0, 0, 0, 0, 0);
        check("b2b_exit_done", 12'b00_0_1_00000000);

        // Saturation: 256 back-to-back entries with start held high.
        step_chk("sat_reset", 1, 0, 0, 0, 0);
        for (int i = 0; i < 256 * 5; i++) step_chk("sat_run", 0, 1, 0, 1, 0);
        check("sat_255_done", 12'b00_0_1_11111111);

        // Reset during P3 of an entry, then a full normal sequence.
        step_chk("rst_mid_start", 0, 1, 0, 2, 0);
        for (int i = 0; i < 4; i++) step_chk("rst_mid_run", 0, 0, 0, 0, 0);
        check("rst_mid_p3", 12'b01_1_0_11111111);
        step_chk("rst_mid_hit", 1, 1, 1, 0, 1);
        check("rst_mid_zero", 12'b00_0_0_00000000);
        step_chk("rst_after_start", 0, 1, 0, 2, 0);
        for (int i = 0; i < 8; i++) step_chk("rst_after_run", 0, 0, 0, 0, 0);
        check("rst_after_done", 12'b00_0_1_00000001);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step_chk("random",
                     ($urandom % 80) == 0,
                     ($urandom % 3) == 0,
                     1'($urandom),
                     8'($urandom_range(0, 4)),
                     ($urandom % 20) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/car_sensor_gen.md
CAR_SENSOR_GEN -- requirements
Module: car_sensor_gen

Interface
REQ-001 Parameter: HOLD_W, default 8, width of the per-phase hold-time input.
REQ-002 Parameter: OCC_W, default 8, width of the occupancy counter.
REQ-003 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  request one car sequence; sampled only in IDLE.
REQ-006 Port: dir  input  1  sequence direction, latched with start: 0 = entry (a leads), 1 = exit (b leads).
REQ-007 Port: hold  input  HOLD_W  cycles per phase, latched with start; 0 is treated as 1.
REQ-008 Port: abort  input  1  terminates the active sequence.
REQ-009 Port: a  output  1  registered sensor-A emulation, to the parking-meter FSM input a.
REQ-010 Port: b  output  1  registered sensor-B emulation, to the parking-meter FSM input b.
REQ-011 Port: busy  output  1  high while a sequence is active (any state other than IDLE).
REQ-012 Port: done  output  1  single-cycle pulse when a sequence completes normally.
REQ-013 Port: occupancy  output  OCC_W  net cars inside: completed entries minus completed exits, saturating.

Function
REQ-014 States SHALL be IDLE, P1, P2, P3, GAP.
REQ-015 The (a,b) pattern per state SHALL be: IDLE 00; entry P1 10, P2 11, P3 01, GAP 00; exit P1 01, P2 11, P3 10, GAP 00.
REQ-016 In IDLE, start=1 and abort=0 at edge k SHALL latch dir and hold_eff = max(hold,1), enter P1, and drive the P1 pattern and busy=1 from cycle k+1.
REQ-017 Each of P1, P2, P3 and GAP SHALL last exactly hold_eff cycles, with transitions P1->P2->P3->GAP->IDLE.
REQ-018 One internal phase counter of HOLD_W bits SHALL time each phase and reload on every state change.
REQ-019 On GAP expiry, the next cycle SHALL have state IDLE, busy=0, and done=1 for exactly one cycle.
REQ-020 A full sequence SHALL occupy 4*hold_eff cycles of busy=1.
REQ-021 occupancy SHALL update on the same edge that asserts done: +1 for entry, -1 for exit.
REQ-022 occupancy SHALL saturate at 2^OCC_W-1 on entry and at 0 on exit; it never wraps.
REQ-023 start while busy=1 SHALL be ignored, and latched dir and hold_eff SHALL not change mid-sequence.
REQ-024 An IDLE cycle with done=1 and start=1 SHALL accept the new sequence (back-to-back operation).
REQ-025 abort=1 in any non-IDLE state SHALL force IDLE, a=b=0 and busy=0 on the next cycle, with no done pulse and no occupancy change.
REQ-026 abort=1 together with start=1 in IDLE SHALL keep the block in IDLE (abort wins).
REQ-027 a and b SHALL never change in the same cycle, except a 11->00 change caused by abort or reset.

Reset
REQ-028 reset=1 SHALL, at the next edge, force state IDLE, a=0, b=0, busy=0, done=0, occupancy=0 and clear the phase counter and latched dir/hold.
REQ-029 reset SHALL take priority over start and abort, including in the middle of a sequence.

Verification
REQ-030 Entry, hold=2, occupancy=0: pulse start -> (a,b) = 10,10,11,11,01,01,00,00, then done=1 for one cycle, occupancy=1.
REQ-031 Exit, hold=0, occupancy=0: pulse start -> (a,b) = 01,11,10,00 at one cycle each, done pulse, occupancy stays 0 (saturated).
REQ-032 Entry, hold=3, abort asserted in the 2nd cycle of P2 -> next cycle a=b=0 and busy=0, no done, occupancy unchanged.
REQ-033 Entry, hold=1, start reasserted with dir=1 while busy, then again in the done cycle -> first request ignored, second starts an exit sequence immediately, occupancy returns to its prior value.
REQ-034 With occupancy preloaded to 255 via 255 entry sequences, one more entry -> occupancy stays 255 and done still pulses.
REQ-035 reset=1 during P3 of an entry sequence -> next cycle all outputs 0, occupancy=0; the next start runs a full normal sequence.
